// File: rtl/neuron_acc_ctrl.sv
// Frame accumulator: sums N_INPUTS unsigned 18-bit operands into a 19-bit result with sticky overflow.
// Optional build macro NEURON_ACC_SAT_EN clamps the accumulator at 19'h7FFFF instead of wrapping.
module neuron_acc_ctrl #(
  parameter int unsigned N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_sum,
  output logic        overflow,
  output logic        busy,
  output logic [7:0]  op_cnt
);

  localparam int unsigned ACC_W = 19;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [SUM_W-1:0] sum_c;
  logic             carry_c;
  logic [ACC_W-1:0] acc_add_c;

  // Single shared adder; bit 19 is the carry out of the accumulator
  assign sum_c   = {1'b0, acc_q} + SUM_W'(in_data);
  assign carry_c = sum_c[ACC_W];

`ifdef NEURON_ACC_SAT_EN
  assign acc_add_c = carry_c ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
  assign acc_add_c = sum_c[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = ACC_W'(in_data);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (LAST_CNT == CNT_W'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_add_c;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | carry_c;
            if (cnt_q + CNT_W'(1) == LAST_CNT) state_d = DONE;
          end
        end
        DONE: begin
          // Sum and overflow hold until taken; overflow stays visible into IDLE
          if (out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Bench for neuron_acc_ctrl (N_INPUTS=4): directed vector table, hand sequences, random run vs frame-level model.
module tb_neuron_acc_ctrl;

  localparam int unsigned N = 4;
`ifdef NEURON_ACC_SAT_EN
  localparam logic [18:0] OVF4_SUM = 19'h7FFFF;
`else
  localparam logic [18:0] OVF4_SUM = 19'h7FFFC;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [17:0] in_data;
  logic [18:0] out_sum;
  logic [7:0]  op_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  neuron_acc_ctrl #(.N_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .overflow(overflow), .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic        v;
    logic [17:0] d;
    logic        o;
    logic        e_ov;
    logic        e_busy;
    logic [7:0]  e_cnt;
    logic        e_ovf;
    logic        chk_sum;
    logic [18:0] e_sum;
  } vec_t;

  vec_t tbl[$];

  // Frame-level reference: running exact sum of accepted operands
  int      m_cnt;
  longint  m_full;
  bit      m_hold;
  bit      m_schk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_ov, input logic e_busy,
                          input logic [7:0] e_cnt, input logic e_ovf,
                          input logic chk_sum, input logic [18:0] e_sum);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!e_ov));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    chk({tag, ".op_cnt"},    32'(op_cnt),    32'(e_cnt));
    chk({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
    if (chk_sum) chk({tag, ".out_sum"}, 32'(out_sum), 32'(e_sum));
  endtask

  task automatic cyc(input logic r, input logic c, input logic v, input logic [17:0] d, input logic o);
    rst_n = r; clr = c; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(input int c, input int v, input int d, input int o, input int ov,
                               input int bz, input int cnt, input int ovf, input int cs, input int sum);
    vec_t r;
    r.c = 1'(c); r.v = 1'(v); r.d = 18'(d); r.o = 1'(o); r.e_ov = 1'(ov); r.e_busy = 1'(bz);
    r.e_cnt = 8'(cnt); r.e_ovf = 1'(ovf); r.chk_sum = 1'(cs); r.e_sum = 19'(sum);
    return r;
  endfunction

  function automatic logic [18:0] model_sum();
`ifdef NEURON_ACC_SAT_EN
    return (m_full > 64'h7FFFF) ? 19'h7FFFF : 19'(m_full);
`else
    return 19'(m_full % 64'h80000);
`endif
  endfunction

  task automatic model_step(input logic r, input logic c, input logic v, input logic [17:0] d, input logic o);
    if (!r || c) begin
      m_cnt = 0; m_full = 0; m_hold = 0; m_schk = 1;
    end else if (m_hold) begin
      if (o) begin m_hold = 0; m_cnt = 0; end
    end else if (v) begin
      if (m_cnt == 0) m_full = 0;
      m_full = m_full + longint'(d);
      m_cnt++;
      m_schk = 0;
      if (m_cnt == int'(N)) m_hold = 1;
    end
  endtask

  initial begin
    // REQ-023 basic sum
    tbl.push_back(row(0,1,1,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,2,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,1,3,0, 0,1,3,0,0,0));
    tbl.push_back(row(0,1,4,0, 1,1,4,0,1,10));
    tbl.push_back(row(0,0,0,1, 0,0,0,0,0,0));
    // Bubbles 7,-,-,8,-,9,10
    tbl.push_back(row(0,1,7,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,8,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,0,0,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,1,9,0, 0,1,3,0,0,0));
    tbl.push_back(row(0,1,10,0, 1,1,4,0,1,34));
    tbl.push_back(row(0,1,55,1, 0,0,0,0,0,0));   // no accept on the take cycle
    // Abort with clr over a 3rd operand, then 5,5,5,5
    tbl.push_back(row(0,1,5,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,6,0, 0,1,2,0,0,0));
    tbl.push_back(row(1,1,9,0, 0,0,0,0,1,0));
    tbl.push_back(row(0,1,5,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,5,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,1,5,0, 0,1,3,0,0,0));
    tbl.push_back(row(0,1,5,0, 1,1,4,0,1,20));
    tbl.push_back(row(0,0,0,1, 0,0,0,0,0,0));
    // Overflow: 4 x 18'h3FFFF, sticky past the take, cleared by next frame
    tbl.push_back(row(0,1,18'h3FFFF,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,18'h3FFFF,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,1,18'h3FFFF,0, 0,1,3,1,0,0));
    tbl.push_back(row(0,1,18'h3FFFF,0, 1,1,4,1,1,int'(OVF4_SUM)));
    tbl.push_back(row(0,0,0,1, 0,0,0,1,0,0));
    tbl.push_back(row(0,1,1,0, 0,1,1,0,0,0));
    tbl.push_back(row(1,0,0,0, 0,0,0,0,1,0));
    // clr in DONE beats out_ready and drops the sum
    tbl.push_back(row(0,1,1,0, 0,1,1,0,0,0));
    tbl.push_back(row(0,1,1,0, 0,1,2,0,0,0));
    tbl.push_back(row(0,1,1,0, 0,1,3,0,0,0));
    tbl.push_back(row(0,1,1,0, 1,1,4,0,1,4));
    tbl.push_back(row(1,0,0,1, 0,0,0,0,1,0));

    // Reset state
    cyc(0,0,0,0,0);
    cyc(0,0,1,18'h123,1);
    chk_outs("reset", 0,0,0,0,1,0);

    foreach (tbl[i]) begin
      cyc(1, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].o);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_cnt,
               tbl[i].e_ovf, tbl[i].chk_sum, tbl[i].e_sum);
    end

    // Backpressure: 5 held cycles with in_valid asserted, then take
    for (int i = 1; i <= 4; i++) cyc(1,0,1,18'(i),0);
    for (int i = 0; i < 5; i++) begin
      cyc(1,0,1,18'h3FFFF,0);
      chk_outs($sformatf("bp%0d", i), 1,1,4,0,1,10);
    end
    cyc(1,0,1,18'h77,1);
    chk_outs("bp_take", 0,0,0,0,0,0);

    // Reset mid-frame discards the partial sum
    for (int i = 0; i < 3; i++) cyc(1,0,1,18'h100,0);
    chk_outs("pre_rst", 0,1,3,0,0,0);
    cyc(0,1,1,18'h5,1);
    chk_outs("mid_rst", 0,0,0,0,1,0);
    for (int i = 1; i <= 4; i++) cyc(1,0,1,18'h1,0);
    chk_outs("post_rst", 1,1,4,0,1,4);
    cyc(1,0,0,0,1);
    chk_outs("post_rst_take", 0,0,0,0,0,0);

    // Random traffic against the frame-level model
    cyc(0,0,0,0,0);
    model_step(0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      logic r, c, v, o;
      logic [17:0] d;
      int sel;
      r = ($urandom_range(0,99) != 0);
      c = ($urandom_range(0,39) == 0);
      v = ($urandom_range(0,9) < 7);
      o = 1'($urandom_range(0,1));
      sel = $urandom_range(0,3);
      d = (sel == 0) ? 18'h0 : (sel == 1) ? 18'($urandom_range(0,255)) : 18'($urandom);
      cyc(r,c,v,d,o);
      model_step(r,c,v,d,o);
      chk_outs("rnd", m_hold, m_hold || (m_cnt != 0), 8'(m_cnt), (m_full > 64'h7FFFF),
               m_hold || m_schk, m_schk ? 19'h0 : model_sum());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_acc_ctrl.md
NEURON_ACC_CTRL -- requirements
Module: neuron_acc_ctrl

Interface
REQ-001 The block SHALL have one parameter, N_INPUTS, default 4, meaning the number of operands summed per frame; legal range 1..255.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports as below.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- clr  input  1  synchronous abort of the current frame
- in_valid  input  1  operand present
- in_ready  output  1  block accepts an operand this cycle
- in_data  input  18  unsigned operand (neuron product term)
- out_valid  output  1  frame sum available
- out_ready  input  1  consumer takes the sum this cycle
- out_sum  output  19  unsigned frame sum
- overflow  output  1  sticky: the sum of the current or last frame exceeded 19 bits
- busy  output  1  a frame is in progress or being held (state is not IDLE)
- op_cnt  output  8  number of operands accepted in the current frame

Function
REQ-003 The block SHALL time-share one 19-bit accumulator fed by a single 19+18-bit adder, and SHALL keep the carry-out as bit 19.
REQ-004 The state machine SHALL have three states: IDLE, ACCUM and DONE.
REQ-005 An input handshake SHALL occur when in_valid=1 and in_ready=1 on a rising clk edge.
REQ-006 In IDLE the block SHALL drive in_ready=1.
- On a handshake: acc <= in_data, op_cnt <= 1, overflow <= 0.
- Next state is DONE if N_INPUTS=1, otherwise ACCUM.
REQ-007 In ACCUM the block SHALL drive in_ready=1.
- On a handshake: acc <= acc+in_data and op_cnt <= op_cnt+1.
- On the handshake that brings op_cnt to N_INPUTS, the next state SHALL be DONE.
REQ-008 A cycle with in_valid=0 SHALL leave acc, op_cnt and the state unchanged.
REQ-009 In DONE the block SHALL drive out_valid=1 and in_ready=0, with out_sum=acc.
- out_sum and overflow SHALL stay stable until out_ready=1.
- Then the next state is IDLE; op_cnt SHALL return to 0, and overflow SHALL hold its value until the next frame starts.
REQ-010 out_valid SHALL rise on the cycle after the last operand handshake, giving a latency of 1 cycle.
REQ-011 out_valid SHALL be 0 in IDLE and ACCUM.
REQ-012 In DONE, in_ready=0 SHALL hold off the next frame; no operand is accepted in the cycle that out_ready is taken.
REQ-013 When an addition produces a carry out of bit 18, overflow SHALL be set to 1 and SHALL stay set for the rest of the frame.
REQ-014 clr=1 SHALL force state IDLE, acc=0, op_cnt=0 and overflow=0 on the next edge, from any state.
- clr SHALL take priority over a simultaneous input handshake or output handshake.
- A clr in DONE SHALL discard the pending sum.
REQ-015 op_cnt SHALL never exceed N_INPUTS; any in_valid outside IDLE/ACCUM SHALL be ignored.
REQ-016 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-017 While rst_n=0 at a rising clk edge, the block SHALL set:
- state to IDLE;
- acc, out_sum, op_cnt, overflow, out_valid and busy to 0;
- in_ready to 1 from the first cycle after reset.
REQ-018 Reset SHALL take priority over clr and over both handshakes.
REQ-019 A reset mid-frame SHALL discard the partial sum with no output.

Configuration
REQ-020 With NEURON_ACC_SAT_EN defined, any addition that carries out of bit 18 SHALL clamp acc to 19'h7FFFF.
- Further additions in the same frame SHALL leave acc at 19'h7FFFF.
REQ-021 Without NEURON_ACC_SAT_EN, acc SHALL wrap modulo 2^19.
REQ-022 overflow behaviour SHALL be identical in both builds.

Verification (N_INPUTS=4)
REQ-023 Basic sum: operands 1,2,3,4 on back-to-back cycles -> out_valid=1 on the cycle after the 4th handshake, out_sum=10, overflow=0.
REQ-024 Overflow: four operands of 18'h3FFFF.
- With NEURON_ACC_SAT_EN -> out_sum=19'h7FFFF, overflow=1.
- Without it -> out_sum=19'h7FFFC, overflow=1.
REQ-025 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_sum stable, in_ready=0 throughout; IDLE on the cycle after out_ready=1.
REQ-026 Bubbles: operands 7, gap, gap, 8, gap, 9, 10 -> out_sum=34, op_cnt stepping 1,1,1,2,2,3,4.
REQ-027 Abort: clr after 2 operands, asserted in the same cycle as a 3rd in_valid -> IDLE with op_cnt=0 next cycle; then 5,5,5,5 -> out_sum=20.
REQ-028 Reset: rst_n=0 for one cycle after 3 operands -> all outputs at reset values; a following frame 1,1,1,1 -> out_sum=4.
